alu_cmd_sequencer: RTL and testbench

Sequential front end for the 6-bit ALU. It accepts opcode/operand commands over a valid/ready handshake, holds a 6-bit accumulator that drives the ALU `a` input, and presents the command operand on `b`. It waits a programmable number of cycles for the ripple-carry paths to settle, then captures the ALU result back into the accumulator. Finally it returns the result with flags over a second valid/ready handshake.

---
 rtl/alu_cmd_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Sequential command front end for the 6-bit ALU: accumulator on a, registered operand on b,
// programmable settle time, result capture with flags and a completed-operation counter.
module alu_cmd_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [2:0]       in_opcode,
  input  logic [5:0]       in_operand,
  output logic [5:0]       alu_a,
  output logic [5:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [5:0]       alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_data,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] CNT_INIT = 2'(EXEC_CYCLES - 1);
  localparam logic [2:0] OP_SLT   = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t           r_state, w_state_next;
  logic [5:0]       r_acc, w_acc_next;
  logic [5:0]       r_alu_b, w_alu_b_next;
  logic [2:0]       r_alu_op, w_alu_op_next;
  logic [1:0]       r_cnt, w_cnt_next;
  logic [5:0]       r_out_data, w_out_data_next;
  logic             r_out_valid, w_out_valid_next;
  logic [CNT_W-1:0] r_op_count, w_op_count_next;
  logic             r_in_ready, w_in_ready_next;

  logic             w_accept;
  logic [5:0]       w_masked;

  assign w_accept = r_in_ready && in_valid && (r_state == S_IDLE);
  // The compare opcode yields a single meaningful bit; upper ALU bits are don't-care.
  assign w_masked = (r_alu_op == OP_SLT) ? {5'b0, alu_result[0]} : alu_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_op_count  <= '0;
      r_in_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_alu_b     <= w_alu_b_next;
      r_alu_op    <= w_alu_op_next;
      r_cnt       <= w_cnt_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_op_count  <= w_op_count_next;
      r_in_ready  <= w_in_ready_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_alu_b_next     = r_alu_b;
    w_alu_op_next    = r_alu_op;
    w_cnt_next       = r_cnt;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_op_count_next  = r_op_count;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_load) begin
            w_acc_next = in_operand;
          end else begin
            w_alu_b_next  = in_operand;
            w_alu_op_next = in_opcode;
            w_cnt_next    = CNT_INIT;
            w_state_next  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (r_cnt != 2'd0) begin
          w_cnt_next = r_cnt - 2'd1;
        end else begin
          w_out_data_next  = w_masked;
          w_out_valid_next = 1'b1;
          if (r_alu_op != OP_SLT) begin
            w_acc_next = w_masked;
          end
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_op_count_next  = r_op_count + CNT_W'(1);
          w_state_next     = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Registered ready: high exactly when the machine will sit in IDLE next cycle.
    w_in_ready_next = (w_state_next == S_IDLE);
  end

  assign in_ready   = r_in_ready;
  assign alu_a      = r_acc;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_op;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_zero   = (r_out_data == 6'd0);
  assign out_neg    = r_out_data[5];
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: command table with scoreboard, backpressure,
// and asynchronous reset during EXEC on a second instance with a longer settle time.
module tb_alu_cmd_sequencer;

  localparam int EXEC_A = 2;
  localparam int EXEC_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (EXEC_CYCLES = 2)
  logic       rst_n, in_valid, in_ready, in_load, out_valid, out_ready, out_zero, out_neg;
  logic [2:0] in_opcode, alu_opcode;
  logic [5:0] in_operand, alu_a, alu_b, alu_result, out_data;
  logic [7:0] op_count;

  // Instance B (EXEC_CYCLES = 4)
  logic       rst4_n, in_valid4, in_ready4, in_load4, out_valid4, out_ready4, out_zero4, out_neg4;
  logic [2:0] in_opcode4, alu_opcode4;
  logic [5:0] in_operand4, alu_a4, alu_b4, alu_result4, out_data4;
  logic [7:0] op_count4;

  // Stand-in ALU; compare opcode returns junk in bits 5:1 so masking is exercised.
  function automatic logic [5:0] alu_model(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b);
    case (op)
      3'b000: return a;
      3'b001: return b;
      3'b010: return 6'd0 - a;
      3'b011: return 6'd0 - b;
      3'b100: return {5'b10110, ($signed(a) < $signed(b))};
      3'b101: return ~(a ^ b);
      3'b110: return a + b;
      default: return a - b;
    endcase
  endfunction

  assign alu_result  = alu_model(alu_opcode, alu_a, alu_b);
  assign alu_result4 = alu_model(alu_opcode4, alu_a4, alu_b4);

  alu_cmd_sequencer #(.EXEC_CYCLES(EXEC_A), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_opcode(in_opcode), .in_operand(in_operand), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero), .out_neg(out_neg),
    .op_count(op_count)
  );

  alu_cmd_sequencer #(.EXEC_CYCLES(EXEC_B), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_load(in_load4),
    .in_opcode(in_opcode4), .in_operand(in_operand4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_opcode(alu_opcode4), .alu_result(alu_result4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_zero(out_zero4), .out_neg(out_neg4),
    .op_count(op_count4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic       load;
    logic [2:0] op;
    logic [5:0] operand;
    logic [5:0] exp_data;
    logic [5:0] exp_acc;
  } vec_t;

  typedef struct {
    logic [5:0] data;
    logic       zero;
    logic       neg;
  } exp_t;

  exp_t       sb_q[$];
  vec_t       vecs[14];
  logic [7:0] exp_count = 8'd0;
  logic [5:0] acc_cur   = 6'd0;
  logic       saw_valid4 = 1'b0;

  function automatic vec_t mk(input logic ld, input logic [2:0] op, input logic [5:0] b,
                              input logic [5:0] d, input logic [5:0] acc);
    vec_t v;
    v.load = ld; v.op = op; v.operand = b; v.exp_data = d; v.exp_acc = acc;
    return v;
  endfunction

  // Scoreboard pop: the negedge before a result handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_pending", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_data", out_data, e.data);
        check("sb_zero", out_zero, e.zero);
        check("sb_neg", out_neg, e.neg);
        $display("txn out: data=%b zero=%0d neg=%0d exp_data=%b", out_data, out_zero, out_neg, e.data);
      end
    end
    if (out_valid4) saw_valid4 = 1'b1;
  end

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_cmd(input vec_t v, input bit auto_ack);
    exp_t e;
    wait_ready();
    in_valid = 1'b1; in_load = v.load; in_opcode = v.op; in_operand = v.operand;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_load = 1'b0;
    in_opcode = 3'($urandom); in_operand = 6'($urandom);
    if (v.load) begin
      @(negedge clk);
      check("load_acc", alu_a, v.exp_acc);
      check("load_ready", in_ready, 1);
      acc_cur = v.exp_acc;
      $display("txn load: operand=%b acc=%b", v.operand, alu_a);
      return;
    end
    e.data = v.exp_data; e.zero = (v.exp_data == 6'd0); e.neg = v.exp_data[5];
    sb_q.push_back(e);
    for (int k = 0; k < EXEC_A; k++) begin
      @(negedge clk);
      check("exec_valid", out_valid, 0);
      check("exec_ready", in_ready, 0);
      check("exec_alu_a", alu_a, acc_cur);
      check("exec_alu_b", alu_b, v.operand);
      check("exec_alu_op", alu_opcode, v.op);
    end
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("hold_ready", in_ready, 0);
    check("acc_after", alu_a, v.exp_acc);
    acc_cur = v.exp_acc;
    $display("txn cmd: op=%b b=%b out_data=%b acc=%b", v.op, v.operand, out_data, alu_a);
    if (auto_ack) begin
      @(negedge clk);
      exp_count++;
      check("op_count", op_count, exp_count);
      check("valid_drop", out_valid, 0);
      check("ready_back", in_ready, 1);
    end
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 3'b000, 6'd5,  6'd0,  6'd5);
    vecs[1]  = mk(1'b0, 3'b110, 6'd3,  6'd8,  6'd8);
    vecs[2]  = mk(1'b1, 3'b000, 6'd31, 6'd0,  6'd31);
    vecs[3]  = mk(1'b0, 3'b110, 6'd1,  6'd32, 6'd32);
    vecs[4]  = mk(1'b0, 3'b111, 6'h20, 6'd0,  6'd0);
    vecs[5]  = mk(1'b1, 3'b000, 6'd61, 6'd0,  6'd61);
    vecs[6]  = mk(1'b0, 3'b100, 6'd2,  6'd1,  6'd61);
    vecs[7]  = mk(1'b0, 3'b100, 6'd60, 6'd0,  6'd61);
    vecs[8]  = mk(1'b0, 3'b010, 6'd0,  6'd3,  6'd3);
    vecs[9]  = mk(1'b0, 3'b101, 6'd5,  6'd57, 6'd57);
    vecs[10] = mk(1'b0, 3'b000, 6'd0,  6'd57, 6'd57);
    vecs[11] = mk(1'b0, 3'b001, 6'd7,  6'd7,  6'd7);
    vecs[12] = mk(1'b0, 3'b011, 6'd7,  6'd57, 6'd57);
    vecs[13] = mk(1'b0, 3'b111, 6'd1,  6'd56, 6'd56);

    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_opcode = 3'd0; in_operand = 6'd0; out_ready = 1'b1;
    rst4_n = 1'b0; in_valid4 = 1'b0; in_load4 = 1'b0; in_opcode4 = 3'd0; in_operand4 = 6'd0; out_ready4 = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_out_neg", out_neg, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_opcode, 0);
    check("rst_op_count", op_count, 0);
    rst_n = 1'b1; rst4_n = 1'b1;
    #1;
    check("rel_ready_pre_edge", in_ready, 0);
    @(negedge clk);
    check("rel_ready_post_edge", in_ready, 1);
    $display("txn reset: released, in_ready=%0d", in_ready);

    // Command table, out_ready held high
    for (int i = 0; i < 14; i++) run_cmd(vecs[i], 1'b1);

    // out_ready high while idle has no effect
    repeat (3) @(negedge clk);
    check("idle_op_count", op_count, exp_count);

    // Backpressure: 56 + 5 = 61
    out_ready = 1'b0;
    run_cmd(mk(1'b0, 3'b110, 6'd5, 6'd61, 6'd61), 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_load = 1'($urandom); in_opcode = 3'($urandom); in_operand = 6'($urandom);
      @(negedge clk);
      check("bp_data", out_data, 6'd61);
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_count", op_count, exp_count);
      check("bp_alu_b", alu_b, 6'd5);
      check("bp_acc", alu_a, acc_cur);
      $display("txn backpressure cycle %0d: out_data=%b in_ready=%0d", c, out_data, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_load = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_count++;
    check("bp_release_count", op_count, exp_count);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(negedge clk);
    check("bp_count_once", op_count, exp_count);
    check("bp_acc_kept", alu_a, acc_cur);

    // Reset in the second EXEC cycle on the EXEC_CYCLES=4 instance
    for (int i = 0; i < 20; i++) begin
      if (in_ready4) break;
      @(negedge clk);
    end
    check("r4_ready", in_ready4, 1);
    in_valid4 = 1'b1; in_load4 = 1'b1; in_operand4 = 6'd9;
    @(posedge clk);
    #1;
    in_load4 = 1'b0; in_opcode4 = 3'b110; in_operand4 = 6'd3;
    @(negedge clk);
    check("r4_load_acc", alu_a4, 6'd9);
    check("r4_load_ready", in_ready4, 1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    check("r4_exec_b", alu_b4, 6'd3);
    check("r4_exec_ready", in_ready4, 0);
    @(posedge clk);
    #3;
    rst4_n = 1'b0;
    #1;
    check("r4_async_acc", alu_a4, 0);
    check("r4_async_b", alu_b4, 0);
    check("r4_async_op", alu_opcode4, 0);
    check("r4_async_ready", in_ready4, 0);
    check("r4_async_valid", out_valid4, 0);
    check("r4_async_data", out_data4, 0);
    check("r4_async_zero", out_zero4, 1);
    check("r4_async_neg", out_neg4, 0);
    check("r4_async_count", op_count4, 0);
    repeat (3) @(negedge clk);
    rst4_n = 1'b1;
    repeat (6) @(negedge clk);
    check("r4_no_valid_pulse", saw_valid4, 0);
    check("r4_post_acc", alu_a4, 0);
    check("r4_post_count", op_count4, 0);
    check("r4_post_ready", in_ready4, 1);
    $display("txn reset-mid-exec: acc=%b out_valid_seen=%0d", alu_a4, saw_valid4);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
